cpureg_seq: RTL and testbench

Register-access sequencer for the PDP2011 CPU, sitting directly upstream of the CPU register file. It turns operand requests (read, write, autoincrement, autodecrement) into register-file address, write-data and write-enable sequences. It forms the 6-bit register-file address from the register number and the PSW register-set and mode bits. It also holds the PC (R7) internally, because the register file has no storage for R7.

---
 rtl/cpureg_seq.sv | 147 ++++++++++++++
 tb/tb_cpureg_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpureg_seq.sv
// Register-access sequencer in front of the CPU register file; holds R7 (PC) locally.
// Latency: read/write done 2 cycles after accept, autoinc/autodec 3; start ignored while busy.
module cpureg_seq #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  rnum,
    input  logic [1:0]  op,
    input  logic        byteop,
    input  logic        usepmode,
    input  logic [15:0] psw,
    input  logic [15:0] wdata,
    input  logic        pc_load,
    input  logic [15:0] pc_in,
    input  logic [15:0] rf_o,
    output logic [5:0]  rf_raddr,
    output logic [5:0]  rf_waddr,
    output logic [15:0] rf_d,
    output logic        rf_we,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [15:0] pc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;

    logic [1:0]  state_q,  state_d;
    logic [5:0]  addr_q,   addr_d;
    logic [2:0]  rnum_q,   rnum_d;
    logic [1:0]  op_q,     op_d;
    logic        byteop_q, byteop_d;
    logic [15:0] old_q,    old_d;
    logic [15:0] rf_d_q,   rf_d_d;
    logic        rf_we_q,  rf_we_d;
    logic [15:0] result_q, result_d;
    logic [15:0] pc_q,     pc_d;

    logic [15:0] rd_val;
    logic [15:0] step;

    // R7 has no register-file storage, so its value comes from the local PC.
    assign rd_val = (rnum_q == 3'd7) ? pc_q : rf_o;
    assign step   = (byteop_q && (rnum_q < 3'd6)) ? 16'd1 : 16'd2;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rnum_d   = rnum_q;
        op_d     = op_q;
        byteop_d = byteop_q;
        old_d    = old_q;
        rf_d_d   = rf_d_q;
        rf_we_d  = 1'b0;
        result_d = result_q;
        pc_d     = pc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = {(usepmode ? psw[13:12] : psw[15:14]), psw[11], rnum};
                    rnum_d   = rnum;
                    op_d     = op;
                    byteop_d = byteop;
                    if (op == OP_WRITE) begin
                        rf_d_d  = wdata;
                        rf_we_d = (rnum != 3'd7);
                        state_d = S_WB;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                old_d = rd_val;
                if (op_q == OP_READ) begin
                    result_d = rd_val;
                    state_d  = S_DONE;
                end else begin
                    rf_d_d  = (op_q == OP_INC) ? rd_val + step : rd_val - step;
                    rf_we_d = (rnum_q != 3'd7);
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (rnum_q == 3'd7) begin
                    pc_d = rf_d_q;
                end
                result_d = (op_q == OP_INC) ? old_q : rf_d_q;
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An external PC load overrides any R7 writeback in the same cycle.
        if (pc_load) begin
            pc_d = pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= 6'd0;
            rnum_q   <= 3'd0;
            op_q     <= 2'd0;
            byteop_q <= 1'b0;
            old_q    <= 16'd0;
            rf_d_q   <= 16'd0;
            rf_we_q  <= 1'b0;
            result_q <= 16'd0;
            pc_q     <= PC_RESET;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rnum_q   <= rnum_d;
            op_q     <= op_d;
            byteop_q <= byteop_d;
            old_q    <= old_d;
            rf_d_q   <= rf_d_d;
            rf_we_q  <= rf_we_d;
            result_q <= result_d;
            pc_q     <= pc_d;
        end
    end

    assign rf_raddr = addr_q;
    assign rf_waddr = addr_q;
    assign rf_d     = rf_d_q;
    assign rf_we    = rf_we_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_cpureg_seq.sv
// Bench for cpureg_seq: directed scenarios plus randomized operations against an operand-level model.
module tb_cpureg_seq;

    localparam logic [15:0] PCR = 16'o000200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  rnum = 3'd0;
    logic [1:0]  op = 2'd0;
    logic        byteop = 1'b0;
    logic        usepmode = 1'b0;
    logic [15:0] psw = 16'd0;
    logic [15:0] wdata = 16'd0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = 16'd0;
    logic [15:0] rf_o;
    logic [5:0]  rf_raddr, rf_waddr;
    logic [15:0] rf_d;
    logic        rf_we, busy, done;
    logic [15:0] result, pc;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf_mem [64];
    logic [15:0] pc_model;

    // Observations of one transaction
    int          obs_lat, obs_nwe, obs_nobusy;
    logic [15:0] obs_res, obs_wd, obs_pc;
    logic [5:0]  obs_waddr, obs_raddr;

    // Expectations of one transaction
    int          exp_lat, exp_nwe;
    logic [15:0] exp_res, exp_wd;
    logic [5:0]  exp_addr;

    cpureg_seq #(.PC_RESET(PCR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rnum(rnum), .op(op),
        .byteop(byteop), .usepmode(usepmode), .psw(psw), .wdata(wdata),
        .pc_load(pc_load), .pc_in(pc_in), .rf_o(rf_o),
        .rf_raddr(rf_raddr), .rf_waddr(rf_waddr), .rf_d(rf_d), .rf_we(rf_we),
        .busy(busy), .done(done), .result(result), .pc(pc)
    );

    always #5 clk = ~clk;

    assign rf_o = rf_mem[rf_raddr];
    always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_d;

    // Operand-level expectation: what the operation means architecturally.
    task automatic model_op(input logic [2:0] r, input logic [1:0] o, input logic b,
                            input logic up, input logic [15:0] p, input logic [15:0] w,
                            input bit pl, input logic [15:0] pin);
        logic [15:0] old, nv;
        int stp;
        exp_addr = {(up ? p[13:12] : p[15:14]), p[11], r};
        stp = (b && r < 6) ? 1 : 2;
        old = (r == 3'd7) ? pc_model : rf_mem[exp_addr];
        case (o)
            2'b00:   begin nv = old;                 exp_res = old; end
            2'b01:   begin nv = w;                   exp_res = w;   end
            2'b10:   begin nv = old + 16'(stp);      exp_res = old; end
            default: begin nv = old - 16'(stp);      exp_res = nv;  end
        endcase
        exp_lat = (o[1]) ? 3 : 2;
        exp_nwe = (o != 2'b00 && r != 3'd7) ? 1 : 0;
        exp_wd  = nv;
        if (r == 3'd7 && o != 2'b00) pc_model = nv;
        if (pl) pc_model = pin;
    endtask

    task automatic do_op(input logic [2:0] r, input logic [1:0] o, input logic b,
                         input logic up, input logic [15:0] p, input logic [15:0] w,
                         input int pl_cyc, input logic [15:0] pin, input bit noisy);
        @(negedge clk);
        start = 1'b1; rnum = r; op = o; byteop = b; usepmode = up; psw = p; wdata = w;
        @(posedge clk); #1;
        start = noisy;
        rnum = 3'($urandom); op = 2'($urandom); byteop = 1'($urandom);
        usepmode = 1'($urandom); psw = 16'($urandom); wdata = 16'($urandom);
        obs_raddr = rf_raddr;
        obs_lat = 0; obs_nwe = 0; obs_nobusy = 0; obs_res = 16'hxxxx;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            pc_load = (c == pl_cyc);
            pc_in = pin;
            if (!busy) obs_nobusy++;
            if (rf_we) begin
                obs_nwe++;
                obs_waddr = rf_waddr;
                obs_wd = rf_d;
            end
            if (done) begin
                obs_lat = c;
                obs_res = result;
                obs_pc = pc;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        pc_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (pc !== PCR) begin errors++; $display("FAIL reset_pc got %h want %h", pc, PCR); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || rf_we !== 1'b0) begin errors++;
            $display("FAIL reset_ctl got busy=%b done=%b we=%b want 0 0 0", busy, done, rf_we); end
        checks++; if (result !== 16'd0 || rf_d !== 16'd0 || rf_raddr !== 6'd0 || rf_waddr !== 6'd0) begin errors++;
            $display("FAIL reset_data got res=%h d=%h ra=%h wa=%h want zeros", result, rf_d, rf_raddr, rf_waddr); end
        @(negedge clk); rst_n = 1'b1;
        pc_model = PCR;
    endtask

    task automatic test_read_pc();
        model_op(3'd7, 2'b00, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0);
        do_op(3'd7, 2'b00, 1'b0, 1'b0, 16'd0, 16'd0, 0, 16'd0, 1'b0);
        checks++; if (obs_res !== 16'o000200 || obs_lat != 2) begin errors++;
            $display("FAIL read_pc got res=%h lat=%0d want 0080 2", obs_res, obs_lat); end
        checks++; if (obs_nwe != 0) begin errors++; $display("FAIL read_pc_we got %0d writes want 0", obs_nwe); end
    endtask

    task automatic test_write_r6();
        do_op(3'd6, 2'b01, 1'b0, 1'b0, 16'o140000, 16'h1234, 0, 16'd0, 1'b0);
        checks++; if (obs_nwe != 1 || obs_waddr !== 6'b110110 || obs_wd !== 16'h1234) begin errors++;
            $display("FAIL write_r6 got n=%0d wa=%b d=%h want 1 110110 1234", obs_nwe, obs_waddr, obs_wd); end
        checks++; if (obs_lat != 2 || obs_res !== 16'h1234) begin errors++;
            $display("FAIL write_r6_done got lat=%0d res=%h want 2 1234", obs_lat, obs_res); end
        repeat (3) @(negedge clk);
        checks++; if (rf_raddr !== 6'b110110 || rf_mem[6'b110110] !== 16'h1234) begin errors++;
            $display("FAIL write_r6_hold got ra=%b mem=%h want 110110 1234", rf_raddr, rf_mem[6'b110110]); end
    endtask

    task automatic test_autodec_wrap();
        rf_mem[6'b001010] = 16'h0000;
        do_op(3'd2, 2'b11, 1'b1, 1'b0, 16'h0800, 16'd0, 0, 16'd0, 1'b0);
        checks++; if (obs_nwe != 1 || obs_waddr !== 6'b001010 || obs_wd !== 16'hFFFF) begin errors++;
            $display("FAIL autodec_wrap got n=%0d wa=%b d=%h want 1 001010 ffff", obs_nwe, obs_waddr, obs_wd); end
        checks++; if (obs_lat != 3 || obs_res !== 16'hFFFF) begin errors++;
            $display("FAIL autodec_res got lat=%0d res=%h want 3 ffff", obs_lat, obs_res); end
    endtask

    task automatic test_autoinc_pmode();
        rf_mem[6'b010110] = 16'h0FFE;
        do_op(3'd6, 2'b10, 1'b1, 1'b1, 16'hD000, 16'd0, 0, 16'd0, 1'b0);
        checks++; if (obs_raddr !== 6'b010110 || obs_wd !== 16'h1000 || obs_nwe != 1) begin errors++;
            $display("FAIL autoinc_r6 got ra=%b d=%h n=%0d want 010110 1000 1", obs_raddr, obs_wd, obs_nwe); end
        checks++; if (obs_res !== 16'h0FFE || obs_lat != 3) begin errors++;
            $display("FAIL autoinc_r6_res got res=%h lat=%0d want 0ffe 3", obs_res, obs_lat); end
    endtask

    task automatic test_pc_r7();
        @(negedge clk); pc_load = 1'b1; pc_in = 16'h2000;
        @(negedge clk); pc_load = 1'b0;
        checks++; if (pc !== 16'h2000) begin errors++; $display("FAIL pc_load_idle got %h want 2000", pc); end
        do_op(3'd7, 2'b10, 1'b0, 1'b0, 16'd0, 16'd0, 2, 16'h3000, 1'b0);
        checks++; if (obs_pc !== 16'h3000 || obs_res !== 16'h2000 || obs_nwe != 0) begin errors++;
            $display("FAIL pc_r7_load got pc=%h res=%h n=%0d want 3000 2000 0", obs_pc, obs_res, obs_nwe); end
        do_op(3'd7, 2'b10, 1'b1, 1'b0, 16'd0, 16'd0, 0, 16'd0, 1'b0);
        checks++; if (obs_pc !== 16'h3002 || obs_res !== 16'h3000) begin errors++;
            $display("FAIL pc_r7_inc got pc=%h res=%h want 3002 3000", obs_pc, obs_res); end
        pc_model = 16'h3002;
    endtask

    task automatic test_reset_midop();
        int seen_done;
        rf_mem[6'd1] = 16'h0100;
        @(negedge clk);
        start = 1'b1; rnum = 3'd1; op = 2'b10; byteop = 1'b0; usepmode = 1'b0; psw = 16'd0;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL midop_wb got we=%b want 1", rf_we); end
        rst_n = 1'b0; #1;
        checks++; if (rf_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== PCR) begin errors++;
            $display("FAIL midop_reset got we=%b busy=%b done=%b pc=%h want 0 0 0 %h", rf_we, busy, done, pc, PCR); end
        pc_model = PCR;
        @(negedge clk); rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || rf_we) seen_done++;
        end
        checks++; if (seen_done != 0 || rf_mem[6'd1] !== 16'h0100) begin errors++;
            $display("FAIL midop_after got events=%0d mem=%h want 0 0100", seen_done, rf_mem[6'd1]); end
        do_op(3'd1, 2'b00, 1'b0, 1'b0, 16'd0, 16'd0, 0, 16'd0, 1'b0);
        checks++; if (obs_res !== 16'h0100 || obs_lat != 2) begin errors++;
            $display("FAIL midop_read got res=%h lat=%0d want 0100 2", obs_res, obs_lat); end
    endtask

    task automatic test_random(input int n, input bit noisy);
        for (int i = 0; i < n; i++) begin
            logic [2:0] r; logic [1:0] o; logic b, up; logic [15:0] p, w, pin;
            int pl_cyc;
            r = 3'($urandom); o = 2'($urandom); b = 1'($urandom); up = 1'($urandom);
            p = 16'($urandom); w = 16'($urandom); pin = 16'($urandom);
            pl_cyc = 0;
            if (o != 2'b00 && $urandom_range(0, 3) == 0) pl_cyc = o[1] ? 2 : 1;
            model_op(r, o, b, up, p, w, pl_cyc != 0, pin);
            do_op(r, o, b, up, p, w, pl_cyc, pin, noisy);
            checks++; if (obs_lat != exp_lat || obs_res !== exp_res) begin errors++;
                $display("FAIL rand_res op=%0d r=%0d got lat=%0d res=%h want %0d %h", o, r, obs_lat, obs_res, exp_lat, exp_res); end
            checks++; if (obs_raddr !== exp_addr || obs_nwe != exp_nwe) begin errors++;
                $display("FAIL rand_addr op=%0d r=%0d got ra=%b n=%0d want %b %0d", o, r, obs_raddr, obs_nwe, exp_addr, exp_nwe); end
            if (exp_nwe == 1) begin
                checks++; if (obs_waddr !== exp_addr || obs_wd !== exp_wd) begin errors++;
                    $display("FAIL rand_wr op=%0d r=%0d got wa=%b d=%h want %b %h", o, r, obs_waddr, obs_wd, exp_addr, exp_wd); end
            end
            checks++; if (obs_pc !== pc_model || obs_nobusy != 0) begin errors++;
                $display("FAIL rand_pc got pc=%h idle_cycles=%0d want %h 0", obs_pc, obs_nobusy, pc_model); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rf_mem[i] = 16'($urandom);
        pc_model = PCR;
        test_reset();
        test_read_pc();
        test_write_r6();
        test_autodec_wrap();
        test_autoinc_pmode();
        test_pc_r7();
        test_reset_midop();
        test_random(40, 1'b0);
        test_random(20, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
